// File: rtl/clk_tick_gen_if.sv
// Control/status bundle for clk_tick_gen: PLL lock and tick enable in,
// downstream reset, tick pulses, heartbeat and sequencer state out.
interface clk_tick_gen_if;
  logic       pll_locked;
  logic       tick_en;
  logic       sys_rst_n;
  logic       tick_slow;
  logic       tick_fast;
  logic       heartbeat;
  logic [1:0] state_o;

  modport master (
    output pll_locked, tick_en,
    input  sys_rst_n, tick_slow, tick_fast, heartbeat, state_o
  );

  modport slave (
    input  pll_locked, tick_en,
    output sys_rst_n, tick_slow, tick_fast, heartbeat, state_o
  );
endinterface

// File: rtl/clk_tick_gen.sv
// PLL-lock reset sequencer plus power-of-two prescaler producing slow/fast
// tick pulses and a heartbeat level, all gated by a stable lock.
module clk_tick_gen #(
  parameter int DIV_LOG2           = 23,
  parameter int FAST_DIV_LOG2      = 20,
  parameter int LOCK_STABLE_CYCLES = 1024
) (
  input logic           clk,
  input logic           rst_n,
  clk_tick_gen_if.slave bus
);
  localparam int SW = (LOCK_STABLE_CYCLES > 2) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_STAB = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_sync;
  logic [SW-1:0]       r_stab_cnt;
  logic [DIV_LOG2-1:0] r_pre_cnt;
  logic                r_sys_rst_n;
  logic                r_tick_slow;
  logic                r_tick_fast;
  logic                r_heartbeat;
  logic                w_locked;
  logic                w_wrap_slow;
  logic                w_wrap_fast;

  assign w_locked    = r_sync[1];
  assign w_wrap_slow = &r_pre_cnt;
  assign w_wrap_fast = &r_pre_cnt[FAST_DIV_LOG2-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT;
      r_sync      <= '0;
      r_stab_cnt  <= '0;
      r_pre_cnt   <= '0;
      r_sys_rst_n <= 1'b0;
      r_tick_slow <= 1'b0;
      r_tick_fast <= 1'b0;
      r_heartbeat <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], bus.pll_locked};
      r_tick_slow <= 1'b0;
      r_tick_fast <= 1'b0;
      case (r_state)
        S_WAIT: begin
          r_stab_cnt  <= '0;
          r_pre_cnt   <= '0;
          r_sys_rst_n <= 1'b0;
          r_heartbeat <= 1'b0;
          if (w_locked) r_state <= S_STAB;
        end
        S_STAB: begin
          r_pre_cnt   <= '0;
          r_sys_rst_n <= 1'b0;
          r_heartbeat <= 1'b0;
          if (!w_locked) begin
            r_state    <= S_WAIT;
            r_stab_cnt <= '0;
          end else if (r_stab_cnt == STAB_LAST) begin
            r_state    <= S_RUN;
            r_stab_cnt <= '0;
          end else begin
            r_stab_cnt <= r_stab_cnt + SW'(1);
          end
        end
        S_RUN: begin
          // Lock loss clears everything on the same edge: no partial-period tick.
          if (!w_locked) begin
            r_state     <= S_WAIT;
            r_sys_rst_n <= 1'b0;
            r_pre_cnt   <= '0;
            r_heartbeat <= 1'b0;
          end else begin
            r_sys_rst_n <= 1'b1;
            if (bus.tick_en) begin
              r_pre_cnt   <= r_pre_cnt + DIV_LOG2'(1);
              r_tick_slow <= w_wrap_slow;
              r_tick_fast <= w_wrap_fast;
              if (w_wrap_slow) r_heartbeat <= ~r_heartbeat;
            end
          end
        end
        default: begin
          r_state     <= S_WAIT;
          r_stab_cnt  <= '0;
          r_pre_cnt   <= '0;
          r_sys_rst_n <= 1'b0;
          r_heartbeat <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sys_rst_n = r_sys_rst_n;
  assign bus.tick_slow = r_tick_slow;
  assign bus.tick_fast = r_tick_fast;
  assign bus.heartbeat = r_heartbeat;
  assign bus.state_o   = r_state;
endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed bench for clk_tick_gen (DIV_LOG2=4, FAST_DIV_LOG2=2, 8 lock cycles);
// expectations are queued per step and popped when the outputs are sampled.
module tb_clk_tick_gen;
  typedef struct packed {
    logic [1:0] st;
    logic       srst;
    logic       slow;
    logic       fast;
    logic       hb;
  } exp_t;

  logic clk;
  logic rst_n;
  clk_tick_gen_if bus();

  clk_tick_gen #(
    .DIV_LOG2(4),
    .FAST_DIV_LOG2(2),
    .LOCK_STABLE_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   vectors;
  int   miscompares;
  int   m_pre;
  bit   m_hb;

  function automatic exp_t mk(input int st, input bit r, input bit s, input bit f, input bit h);
    exp_t e;
    e.st = 2'(st); e.srst = r; e.slow = s; e.fast = f; e.hb = h;
    return e;
  endfunction

  task automatic check(input string tag);
    exp_t e;
    exp_t o;
    e = q.pop_front();
    o = {bus.state_o, bus.sys_rst_n, bus.tick_slow, bus.tick_fast, bus.heartbeat};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed st=%0d rst=%b slow=%b fast=%b hb=%b, expected st=%0d rst=%b slow=%b fast=%b hb=%b",
             tag, o.st, o.srst, o.slow, o.fast, o.hb, e.st, e.srst, e.slow, e.fast, e.hb);
    end
  endtask

  task automatic expect_now(input string tag, input exp_t e);
    q.push_back(e);
    check(tag);
  endtask

  task automatic step(input string tag, input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // One RUN cycle with lock held; expectation from a plain prescaler model.
  task automatic run_cyc(input string tag, input bit en);
    bit s;
    bit f;
    bus.tick_en = en;
    s = en && (m_pre == 15);
    f = en && ((m_pre % 4) == 3);
    if (en) m_pre = (m_pre + 1) % 16;
    if (s) m_hb = ~m_hb;
    step(tag, mk(2, 1'b1, s, f, m_hb));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_pre       = 0;
    m_hb        = 1'b0;
    rst_n          = 1'b0;
    bus.pll_locked = 1'b1;
    bus.tick_en    = 1'b1;
    #3;
    expect_now("reset_state", mk(0, 0, 0, 0, 0));

    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Power-up: two synchronizer edges, then eight stabilize edges.
    step("sync1", mk(0, 0, 0, 0, 0));
    step("sync2", mk(0, 0, 0, 0, 0));
    step("enter_stab", mk(1, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) step("stab", mk(1, 0, 0, 0, 0));
    step("enter_run", mk(2, 0, 0, 0, 0));

    for (int i = 0; i < 40; i++) run_cyc("run_free", 1'b1);

    // Pause the prescaler at pre_cnt=7 for 5 cycles.
    while (m_pre != 7) run_cyc("run_to7", 1'b1);
    for (int i = 0; i < 5; i++) run_cyc("paused", 1'b0);
    for (int i = 0; i < 20; i++) run_cyc("resumed", 1'b1);

    // Lock loss at pre_cnt=10: two synchronizer edges, then full clear.
    while (m_pre != 10) run_cyc("run_to10", 1'b1);
    bus.pll_locked = 1'b0;
    run_cyc("loss_sync1", 1'b1);
    run_cyc("loss_sync2", 1'b1);
    step("loss_clear", mk(0, 0, 0, 0, 0));
    m_pre = 0;
    m_hb  = 1'b0;
    for (int i = 0; i < 3; i++) step("wait_unlocked", mk(0, 0, 0, 0, 0));

    // Relock with a one-cycle glitch mid-stabilize.
    bus.pll_locked = 1'b1;
    step("relock_sync1", mk(0, 0, 0, 0, 0));
    step("relock_sync2", mk(0, 0, 0, 0, 0));
    step("relock_stab", mk(1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) step("relock_cnt", mk(1, 0, 0, 0, 0));
    bus.pll_locked = 1'b0;
    step("glitch_s1", mk(1, 0, 0, 0, 0));
    bus.pll_locked = 1'b1;
    step("glitch_s2", mk(1, 0, 0, 0, 0));
    step("glitch_drop", mk(0, 0, 0, 0, 0));
    step("glitch_restab", mk(1, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) step("glitch_cnt", mk(1, 0, 0, 0, 0));
    step("glitch_run", mk(2, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) run_cyc("run_after_glitch", 1'b1);

    // Asynchronous reset between edges while in RUN.
    #3;
    rst_n = 1'b0;
    #1;
    expect_now("async_reset", mk(0, 0, 0, 0, 0));
    @(posedge clk); #1;
    expect_now("held_reset", mk(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step("restart_s1", mk(0, 0, 0, 0, 0));
    step("restart_s2", mk(0, 0, 0, 0, 0));
    step("restart_stab", mk(1, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
